shuffle_solve_ctrl: RTL

- Game and audio sequencer for the Basys3 shuffle/solve puzzle.
- Debounces btnC and, in shuffle mode (sw15=1) or solve mode (sw15=0), updates a move counter.
- Schedules feedback tones on the shared PWM tone generator and powers the Pmod amplifier (amp_shdn/amp_gain) only when it is needed.
- Sits between board I/O and the tone generator that drives audio_out.

---
 rtl/shuffle_solve_pkg.sv | 29 ++
 rtl/shuffle_solve_ctrl_btn_debounce.sv | 45 ++++
 rtl/shuffle_solve_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/shuffle_solve_pkg.sv
// Shared types for the shuffle/solve puzzle sequencer: tone codes, audio states, modes.
package shuffle_solve_pkg;

  typedef enum logic [1:0] {
    CLICK_SHUF  = 2'd0,
    CLICK_SOLVE = 2'd1,
    ERROR       = 2'd2,
    VICTORY     = 2'd3
  } tone_e;

  typedef enum logic [2:0] {
    OFF   = 3'd0,
    WAKE  = 3'd1,
    START = 3'd2,
    PLAY  = 3'd3,
    HOLD  = 3'd4
  } audio_state_e;

  typedef enum logic {
    SOLVE   = 1'b0,
    SHUFFLE = 1'b1
  } mode_e;

  // Victory runs at the louder 12 dB setting; everything else at 6 dB.
  function automatic logic tone_gain(input tone_e code);
    return (code == VICTORY) ? 1'b0 : 1'b1;
  endfunction

endpackage

// File: rtl/shuffle_solve_ctrl_btn_debounce.sv
// Two-flop synchronizer, counter debouncer and rising-edge press pulse for a raw button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic          btn_p0;
  logic          btn_p1;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_p0  <= 1'b0;
      btn_p1  <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= RELOAD;
    end else begin
      btn_p0  <= btn;
      btn_p1  <= btn_p0;
      level_q <= level;
      // Any cycle agreeing with the current level restarts the stability window.
      if (btn_p1 == level) begin
        cnt <= RELOAD;
      end else if (cnt == '0) begin
        level <= btn_p1;
        cnt   <= RELOAD;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/shuffle_solve_ctrl.sv
// Game/audio sequencer: button moves, move counter, tone scheduling and amplifier power.
// Optional macro SHUFFLE_SOLVE_AMP_AUTO_SHDN_EN lets HOLD time out and shut the amplifier down.
module shuffle_solve_ctrl
  import shuffle_solve_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int AMP_WAKE_CYCLES = 100000,
  parameter int HOLD_CYCLES     = 5000000,
  parameter int MAX_MOVES       = 15,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw15,
  input  logic             btnC,
  input  logic             tone_busy,
  output logic             tone_start,
  output logic [1:0]       tone_sel,
  output logic             amp_shdn,
  output logic             amp_gain,
  output logic [CNT_W-1:0] move_count,
  output logic             solved
);

  localparam int WAKE_W = (AMP_WAKE_CYCLES > 1) ? $clog2(AMP_WAKE_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_MOVES);

  logic              sw15_p0;
  logic              sw15_p1;
  logic              press;
  logic              req_vld;
  tone_e             req_code;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              solved_nxt;
  logic              pend_vld;
  tone_e             pend_code;
  logic              eff_vld;
  tone_e             eff_code;
  logic              start_ld;
  tone_e             tone_sel_q;
  audio_state_e      state;
  audio_state_e      state_nxt;
  logic [WAKE_W-1:0] wake_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk  (clk),
    .rst  (rst),
    .btn  (btnC),
    .press(press)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw15_p0 <= 1'b0;
      sw15_p1 <= 1'b0;
    end else begin
      sw15_p0 <= sw15;
      sw15_p1 <= sw15_p0;
    end
  end

  // Move rules, evaluated in the press cycle with the synchronized mode.
  always_comb begin
    req_code   = ERROR;
    cnt_nxt    = move_count;
    solved_nxt = solved;
    if (mode_e'(sw15_p1) == SHUFFLE) begin
      if (move_count < MAX_CNT) begin
        cnt_nxt    = move_count + CNT_W'(1);
        solved_nxt = 1'b0;
        req_code   = CLICK_SHUF;
      end
    end else if (move_count > CNT_W'(1)) begin
      cnt_nxt  = move_count - CNT_W'(1);
      req_code = CLICK_SOLVE;
    end else if (move_count == CNT_W'(1)) begin
      cnt_nxt    = '0;
      solved_nxt = 1'b1;
      req_code   = VICTORY;
    end
  end

  assign req_vld = press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      move_count <= '0;
      solved     <= 1'b0;
    end else if (press) begin
      move_count <= cnt_nxt;
      solved     <= solved_nxt;
    end
  end

  // A request in the same cycle counts as pending and is the newest entry.
  assign eff_vld  = req_vld | pend_vld;
  assign eff_code = req_vld ? req_code : pend_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= OFF;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      OFF:   if (eff_vld) state_nxt = WAKE;
      WAKE:  if (wake_cnt == '0) state_nxt = START;
      START: if (tone_busy) state_nxt = PLAY;
      PLAY:  if (!tone_busy) state_nxt = HOLD;
      HOLD: begin
        if (eff_vld) begin
          state_nxt = START;
        end
`ifdef SHUFFLE_SOLVE_AMP_AUTO_SHDN_EN
        else if (hold_cnt == '0) begin
          state_nxt = OFF;
        end
`endif
      end
      default: state_nxt = OFF;
    endcase
  end

  always_comb begin
    tone_start = (state == START);
    amp_shdn   = (state != OFF);
  end

  assign start_ld = (state_nxt == START) && (state != START);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld   <= 1'b0;
      tone_sel_q <= CLICK_SHUF;
      amp_gain   <= 1'b1;
      wake_cnt   <= '0;
      hold_cnt   <= '0;
    end else begin
      if (start_ld) begin
        pend_vld   <= 1'b0;
        tone_sel_q <= eff_code;
        amp_gain   <= tone_gain(eff_code);
      end else if (req_vld) begin
        pend_vld <= 1'b1;
      end
      if (state == OFF && state_nxt == WAKE) begin
        wake_cnt <= WAKE_W'(AMP_WAKE_CYCLES - 1);
      end else if (state == WAKE && wake_cnt != '0) begin
        wake_cnt <= wake_cnt - WAKE_W'(1);
      end
      if (state == PLAY && state_nxt == HOLD) begin
        hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
      end else if (state == HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end
    end
  end

  // Code storage only matters while pend_vld is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (req_vld && !start_ld) pend_code <= req_code;
  end

  assign tone_sel = tone_sel_q;

endmodule
